// File: rtl/mem_stage_bus_if.sv
// Data-memory bus between the MEM stage (master) and the memory/arbiter (slave).
interface mem_stage_bus_if #(
   parameter int AW = 11
);
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [3:0]    bus_be;
   logic [31:0]   bus_wdata;
   logic          bus_ack;
   logic [31:0]   bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_stage_bus.sv
// Pipeline MEM stage: issues one bus transaction per load/store, stalls upstream
// until ack or timeout, and registers the MEM/WB result.
module mem_stage_bus #(
   parameter int AW       = 11,
   parameter int MAX_WAIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic        dmem_ena_i,
   input  logic        dmem_wena_i,
   input  logic [1:0]  dmem_type_i,
   input  logic        dmem_signed_i,
   input  logic [31:0] rt_data_i,
   input  logic [31:0] alu_result_i,
   input  logic [4:0]  rd_waddr_i,
   input  logic        rd_sel_i,
   input  logic        rd_wena_i,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic        rd_sel_o,
   output logic        rd_wena_o,
   output logic [4:0]  rd_waddr_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] dmem_data_o,
   output logic        misalign_o,
   output logic        timeout_o,
   mem_stage_bus_if.master bus
);

   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t        state_reg, state_next;
   logic [7:0]    wait_cnt_reg;

   logic [AW-1:0] addr_reg;
   logic [3:0]    be_reg;
   logic [31:0]   wdata_reg;
   logic          we_reg;
   logic [1:0]    type_reg;
   logic          signed_reg;
   logic [1:0]    off_reg;
   logic [4:0]    rd_waddr_reg;
   logic          rd_sel_reg;
   logic          rd_wena_reg;
   logic [31:0]   alu_reg;

   logic          is_half, is_byte, misaligned;
   logic          start, ack_hit, timeout_hit;
   logic          bus_req_int, stall_int;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc;
   logic [7:0]    rbyte [4];
   logic [15:0]   half_sel;
   logic [7:0]    byte_sel;
   logic [31:0]   load_data;

   logic          wb_valid_reg, wb_valid_next;
   logic          wb_rd_sel_reg, wb_rd_sel_next;
   logic          wb_rd_wena_reg, wb_rd_wena_next;
   logic [4:0]    wb_rd_waddr_reg, wb_rd_waddr_next;
   logic [31:0]   wb_alu_reg, wb_alu_next;
   logic [31:0]   wb_dmem_reg, wb_dmem_next;
   logic          wb_misalign_reg, wb_misalign_next;
   logic          wb_timeout_reg, wb_timeout_next;

   // Access decode; type 11 falls through to the word path.
   assign is_half    = (dmem_type_i == 2'b01);
   assign is_byte    = (dmem_type_i == 2'b10);
   assign misaligned = is_half ? alu_result_i[0]
                               : (!is_byte && (alu_result_i[1:0] != 2'b00));

   assign start       = (state_reg == IDLE) && valid_i && dmem_ena_i && !misaligned;
   assign ack_hit     = (state_reg == BUS) && bus.bus_ack;
   assign timeout_hit = (state_reg == BUS) && !bus.bus_ack && (wait_cnt_reg == WAIT_LAST);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign be_calc[gi] = is_byte ? (alu_result_i[1:0] == 2'(gi))
                            : is_half ? (alu_result_i[1] == 1'(gi / 2))
                            : 1'b1;
         assign wdata_calc[8*gi +: 8] = is_byte ? rt_data_i[7:0]
                                      : is_half ? rt_data_i[8*(gi%2) +: 8]
                                      : rt_data_i[8*gi +: 8];
         assign rbyte[gi] = bus.bus_rdata[8*gi +: 8];
      end
   endgenerate

   assign half_sel = off_reg[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
   assign byte_sel = rbyte[off_reg];

   always_comb begin
      load_data = bus.bus_rdata;
      case (type_reg)
         2'b01:   load_data = {{16{signed_reg & half_sel[15]}}, half_sel};
         2'b10:   load_data = {{24{signed_reg & byte_sel[7]}}, byte_sel};
         default: load_data = bus.bus_rdata;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = BUS;
         BUS:     if (ack_hit || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus_req_int = 1'b0;
      stall_int   = 1'b0;
      case (state_reg)
         IDLE: stall_int = start;
         BUS: begin
            bus_req_int = 1'b1;
            stall_int   = !bus.bus_ack && !timeout_hit;
         end
         default: stall_int = 1'b0;
      endcase
   end

   // Stall is combinational from inputs, so it must be masked while reset is held.
   assign stall_o       = stall_int & rst_n_i;
   assign bus.bus_req   = bus_req_int;
   assign bus.bus_we    = we_reg;
   assign bus.bus_addr  = addr_reg;
   assign bus.bus_be    = be_reg;
   assign bus.bus_wdata = wdata_reg;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt_reg <= '0;
         addr_reg     <= '0;
         be_reg       <= '0;
         wdata_reg    <= '0;
         we_reg       <= 1'b0;
         type_reg     <= '0;
         signed_reg   <= 1'b0;
         off_reg      <= '0;
         rd_waddr_reg <= '0;
         rd_sel_reg   <= 1'b0;
         rd_wena_reg  <= 1'b0;
         alu_reg      <= '0;
      end else if (start) begin
         wait_cnt_reg <= '0;
         addr_reg     <= alu_result_i[AW+1:2];
         be_reg       <= be_calc;
         wdata_reg    <= wdata_calc;
         we_reg       <= dmem_wena_i;
         type_reg     <= dmem_type_i;
         signed_reg   <= dmem_signed_i;
         off_reg      <= alu_result_i[1:0];
         rd_waddr_reg <= rd_waddr_i;
         rd_sel_reg   <= rd_sel_i;
         rd_wena_reg  <= rd_wena_i;
         alu_reg      <= alu_result_i;
      end else if (state_reg == BUS && !bus.bus_ack) begin
         wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
   end

   always_comb begin
      wb_valid_next    = 1'b0;
      wb_rd_wena_next  = 1'b0;
      wb_misalign_next = 1'b0;
      wb_timeout_next  = 1'b0;
      wb_rd_sel_next   = wb_rd_sel_reg;
      wb_rd_waddr_next = wb_rd_waddr_reg;
      wb_alu_next      = wb_alu_reg;
      wb_dmem_next     = wb_dmem_reg;
      if (state_reg == IDLE && valid_i && (!dmem_ena_i || misaligned)) begin
         wb_valid_next    = 1'b1;
         wb_rd_sel_next   = rd_sel_i;
         wb_rd_waddr_next = rd_waddr_i;
         wb_alu_next      = alu_result_i;
         wb_dmem_next     = '0;
         wb_rd_wena_next  = rd_wena_i & !dmem_ena_i;
         wb_misalign_next = dmem_ena_i;
      end else if (ack_hit || timeout_hit) begin
         wb_valid_next    = 1'b1;
         wb_rd_sel_next   = rd_sel_reg;
         wb_rd_waddr_next = rd_waddr_reg;
         wb_alu_next      = alu_reg;
         wb_rd_wena_next  = ack_hit & rd_wena_reg;
         wb_timeout_next  = timeout_hit;
         wb_dmem_next     = (ack_hit && !we_reg) ? load_data : 32'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wb_valid_reg    <= 1'b0;
         wb_rd_sel_reg   <= 1'b0;
         wb_rd_wena_reg  <= 1'b0;
         wb_rd_waddr_reg <= '0;
         wb_alu_reg      <= '0;
         wb_dmem_reg     <= '0;
         wb_misalign_reg <= 1'b0;
         wb_timeout_reg  <= 1'b0;
      end else begin
         wb_valid_reg    <= wb_valid_next;
         wb_rd_sel_reg   <= wb_rd_sel_next;
         wb_rd_wena_reg  <= wb_rd_wena_next;
         wb_rd_waddr_reg <= wb_rd_waddr_next;
         wb_alu_reg      <= wb_alu_next;
         wb_dmem_reg     <= wb_dmem_next;
         wb_misalign_reg <= wb_misalign_next;
         wb_timeout_reg  <= wb_timeout_next;
      end
   end

   assign wb_valid_o   = wb_valid_reg;
   assign rd_sel_o     = wb_rd_sel_reg;
   assign rd_wena_o    = wb_rd_wena_reg;
   assign rd_waddr_o   = wb_rd_waddr_reg;
   assign alu_result_o = wb_alu_reg;
   assign dmem_data_o  = wb_dmem_reg;
   assign misalign_o   = wb_misalign_reg;
   assign timeout_o    = wb_timeout_reg;

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: a queue-based result model checked every cycle,
// plus literal expectations for the reference scenarios.
module tb_mem_stage_bus;
   localparam int AW       = 11;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, dmem_ena, dmem_wena, dmem_signed;
   logic [1:0]  dmem_type;
   logic [31:0] rt_data, alu_result;
   logic [4:0]  rd_waddr;
   logic        rd_sel, rd_wena;
   logic        stall, wb_valid, rd_sel_q, rd_wena_q, misalign, timeout;
   logic [4:0]  rd_waddr_q;
   logic [31:0] alu_result_q, dmem_data;

   mem_stage_bus_if #(.AW(AW)) bus_if ();

   mem_stage_bus #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .dmem_ena_i(dmem_ena),
      .dmem_wena_i(dmem_wena), .dmem_type_i(dmem_type), .dmem_signed_i(dmem_signed),
      .rt_data_i(rt_data), .alu_result_i(alu_result), .rd_waddr_i(rd_waddr),
      .rd_sel_i(rd_sel), .rd_wena_i(rd_wena), .stall_o(stall), .wb_valid_o(wb_valid),
      .rd_sel_o(rd_sel_q), .rd_wena_o(rd_wena_q), .rd_waddr_o(rd_waddr_q),
      .alu_result_o(alu_result_q), .dmem_data_o(dmem_data), .misalign_o(misalign),
      .timeout_o(timeout), .bus(bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] alu;
      logic [4:0]  waddr;
      logic        sel;
      logic        wena;
      logic [31:0] dmem;
      logic        mis;
      logic        tmo;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   en_cmp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
      end
   endtask

   // Every cycle: either the scheduled completion appears, or nothing does.
   always @(negedge clk) begin
      if (en_cmp) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("alu_result_o", alu_result_q, e.alu);
            chk("rd_waddr_o", 32'(rd_waddr_q), 32'(e.waddr));
            chk("rd_sel_o", 32'(rd_sel_q), 32'(e.sel));
            chk("rd_wena_o", 32'(rd_wena_q), 32'(e.wena));
            chk("dmem_data_o", dmem_data, e.dmem);
            chk("misalign_o", 32'(misalign), 32'(e.mis));
            chk("timeout_o", 32'(timeout), 32'(e.tmo));
         end else begin
            chk("idle_wb_valid", 32'(wb_valid), 32'd0);
            chk("idle_rd_wena", 32'(rd_wena_q), 32'd0);
            chk("idle_misalign", 32'(misalign), 32'd0);
            chk("idle_timeout", 32'(timeout), 32'd0);
         end
      end
   end

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      valid = 1'b0; dmem_ena = 1'b0; dmem_wena = 1'b0; dmem_type = 2'b00;
      dmem_signed = 1'b0; bus_if.bus_ack = 1'b0;
   endtask

   // ack_at: index of the bus cycle carrying ack (-1 = never).
   task automatic do_op(input logic ena, input logic wena, input logic [1:0] typ,
                        input logic sgn, input logic [31:0] rt, input logic [31:0] addr,
                        input logic [4:0] waddr, input logic sel, input logic rwena,
                        input int ack_at, input logic [31:0] rdata,
                        output int stall_cnt, output int req_cnt,
                        output logic [3:0] be_seen, output logic [31:0] wdata_seen,
                        output logic [31:0] addr_seen);
      int          t0, size, off;
      bit          mis, done;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_addr, sh, v;
      logic [63:0] m;
      exp_t        e;
      t0 = cyc;
      stall_cnt = 0; req_cnt = 0; be_seen = '0; wdata_seen = '0; addr_seen = '0;
      valid = 1'b1; dmem_ena = ena; dmem_wena = wena; dmem_type = typ;
      dmem_signed = sgn; rt_data = rt; alu_result = addr; rd_waddr = waddr;
      rd_sel = sel; rd_wena = rwena; bus_if.bus_ack = 1'b0;
      size = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
      off  = int'(addr[1:0]);
      mis  = ena && ((off % size) != 0);
      e.alu = addr; e.waddr = waddr; e.sel = sel; e.dmem = '0; e.mis = 1'b0; e.tmo = 1'b0;
      if (!ena || mis) begin
         @(negedge clk);
         chk("pass_stall", 32'(stall), 32'd0);
         chk("pass_bus_req", 32'(bus_if.bus_req), 32'd0);
         e.cyc = t0 + 1; e.wena = mis ? 1'b0 : rwena; e.mis = mis;
         exp_q.push_back(e);
         advance();
      end else begin
         m       = (64'd1 << (8 * size)) - 64'd1;
         e_be    = 4'(((1 << size) - 1) << off);
         e_wdata = (size == 4) ? rt : (size == 2) ? {2{rt[15:0]}} : {4{rt[7:0]}};
         e_addr  = 32'(addr[AW+1:2]);
         @(negedge clk);
         chk("start_stall", 32'(stall), 32'd1);
         chk("start_bus_req", 32'(bus_if.bus_req), 32'd0);
         if (stall) stall_cnt++;
         advance();
         done = 1'b0;
         for (int i = 0; i < MAX_WAIT && !done; i++) begin
            bus_if.bus_ack   = (i == ack_at);
            bus_if.bus_rdata = (i == ack_at) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            chk("bus_req", 32'(bus_if.bus_req), 32'd1);
            chk("bus_addr", 32'(bus_if.bus_addr), e_addr);
            chk("bus_be", 32'(bus_if.bus_be), 32'(e_be));
            chk("bus_wdata", bus_if.bus_wdata, e_wdata);
            chk("bus_we", 32'(bus_if.bus_we), 32'(wena));
            chk("bus_stall", 32'(stall), 32'((i != ack_at) && (i != MAX_WAIT - 1)));
            if (stall) stall_cnt++;
            if (bus_if.bus_req) req_cnt++;
            be_seen = bus_if.bus_be; wdata_seen = bus_if.bus_wdata;
            addr_seen = 32'(bus_if.bus_addr);
            if (i == ack_at) begin
               sh = rdata >> (8 * off);
               v  = sh & m[31:0];
               if (sgn && size < 4 && sh[8*size-1]) v = v | ~m[31:0];
               e.cyc = t0 + 2 + i; e.wena = rwena; e.dmem = wena ? 32'd0 : v;
               exp_q.push_back(e);
               done = 1'b1;
            end else if (i == MAX_WAIT - 1) begin
               e.cyc = t0 + 2 + i; e.wena = 1'b0; e.tmo = 1'b1;
               exp_q.push_back(e);
               done = 1'b1;
            end
            advance();
         end
      end
      clear_inputs();
   endtask

   int          sc, rc;
   logic [3:0]  be_s;
   logic [31:0] wd_s, ad_s;

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rt_data = '0; rd_waddr = '0; rd_sel = 1'b0; rd_wena = 1'b0;
      bus_if.bus_rdata = '0;
      clear_inputs();
      // Aligned load presented during reset: stall must still be held low.
      valid = 1'b1; dmem_ena = 1'b1; alu_result = 32'h0000_0010;
      advance(); advance();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_rd_wena", 32'(rd_wena_q), 32'd0);
      chk("rst_alu_result", alu_result_q, 32'd0);
      chk("rst_dmem_data", dmem_data, 32'd0);
      chk("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
      clear_inputs();
      rst_n = 1'b1;
      en_cmp = 1'b1;

      // Ack while idle is ignored.
      bus_if.bus_ack = 1'b1;
      @(negedge clk);
      chk("idle_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
      advance();
      clear_inputs();

      // ALU pass-through.
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 1'b0, 1'b1, -1, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_alu_result", alu_result_q, 32'h0000_1234);
      chk("lit_alu_waddr", 32'(rd_waddr_q), 32'd5);
      advance();

      // Signed byte load, ack after two wait cycles.
      do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0, 32'h0000_0003, 5'd7, 1'b1, 1'b1, 2, 32'h80FF_FF7F,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_byte_stall_cycles", 32'(sc), 32'd3);
      chk("lit_byte_be", 32'(be_s), 32'b1000);
      chk("lit_byte_dmem", dmem_data, 32'hFFFF_FF80);
      advance();

      // Half store.
      do_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_0006, 5'd0, 1'b0, 1'b0, 0, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      chk("lit_half_be", 32'(be_s), 32'b1100);
      chk("lit_half_wdata", wd_s, 32'hABCD_ABCD);
      chk("lit_half_addr", ad_s, 32'd1);

      // Misaligned word load, back to back with the store completion.
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0002, 5'd9, 1'b0, 1'b1, 0, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_mis_misalign", 32'(misalign), 32'd1);
      chk("lit_mis_wb_valid", 32'(wb_valid), 32'd1);
      chk("lit_mis_rd_wena", 32'(rd_wena_q), 32'd0);
      advance();

      // Timeout: no ack at all.
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0020, 5'd3, 1'b0, 1'b1, -1, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_tmo_req_cycles", 32'(rc), 32'd4);
      chk("lit_tmo_bus_req_after", 32'(bus_if.bus_req), 32'd0);
      chk("lit_tmo_timeout", 32'(timeout), 32'd1);
      chk("lit_tmo_rd_wena", 32'(rd_wena_q), 32'd0);
      advance();

      // Ack in the last allowed cycle wins over timeout.
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0024, 5'd4, 1'b1, 1'b1, 3, 32'hCAFE_F00D,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_late_timeout", 32'(timeout), 32'd0);
      chk("lit_late_dmem", dmem_data, 32'hCAFE_F00D);
      advance();

      // Further lane/extension patterns, partly back to back.
      do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0002, 5'd10, 1'b0, 1'b1, 1, 32'h8001_1234,
            sc, rc, be_s, wd_s, ad_s);
      do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0000, 5'd11, 1'b0, 1'b1, 0, 32'h1234_F00F,
            sc, rc, be_s, wd_s, ad_s);
      do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0001, 5'd12, 1'b0, 1'b1, 0, 32'h1122_3344,
            sc, rc, be_s, wd_s, ad_s);
      @(negedge clk);
      chk("lit_ubyte_dmem", dmem_data, 32'h0000_0033);
      advance();
      do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0005, 5'd13, 1'b0, 1'b1, 0, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      do_op(1'b1, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0000_0008, 5'd14, 1'b0, 1'b1, 1, 32'h8765_4321,
            sc, rc, be_s, wd_s, ad_s);
      do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_005A, 32'h0000_0001, 5'd15, 1'b0, 1'b0, 2, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      chk("lit_bstore_be", 32'(be_s), 32'b0010);
      chk("lit_bstore_wdata", wd_s, 32'h5A5A_5A5A);
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_0001, 5'd31, 1'b1, 1'b1, -1, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0042, 5'd1, 1'b0, 1'b0, -1, 32'h0,
            sc, rc, be_s, wd_s, ad_s);

      // Reset in the middle of a bus transaction.
      valid = 1'b1; dmem_ena = 1'b1; dmem_type = 2'b00; alu_result = 32'h0000_0010;
      rd_waddr = 5'd2; rd_wena = 1'b1;
      @(negedge clk);
      chk("abort_start_stall", 32'(stall), 32'd1);
      advance();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_wb_valid", 32'(wb_valid), 32'd0);
      advance(); advance();
      clear_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) advance();

      // First instruction after reset handled normally.
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0077, 5'd6, 1'b1, 1'b1, -1, 32'h0,
            sc, rc, be_s, wd_s, ad_s);
      for (int i = 0; i < 3; i++) advance();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_bus.md
MEM_STAGE_BUS -- requirements
Module: mem_stage_bus

Interface
REQ-001 SHALL have parameter AW, default 11, meaning data-memory word-index width (bus_addr_o = alu_result_i[AW+1:2]).
REQ-002 SHALL have parameter MAX_WAIT, default 15, range 1..255, meaning maximum cycles bus_req_o waits for bus_ack_i.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  an instruction is present in MEM this cycle.
REQ-006 dmem_ena_i, dmem_wena_i  in  1 each  memory access / store.
REQ-007 dmem_type_i  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-008 dmem_signed_i  in  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-009 rt_data_i, alu_result_i  in  32 each  store data, effective address / ALU result.
REQ-010 rd_waddr_i  in  5; rd_sel_i, rd_wena_i  in  1 each  writeback controls.
REQ-011 stall_o  out  1  upstream SHALL hold all inputs while high.
REQ-012 bus_req_o, bus_we_o  out  1 each; bus_addr_o  out  AW; bus_be_o  out  4; bus_wdata_o  out  32.
REQ-013 bus_ack_i  in  1; bus_rdata_i  in  32  valid when bus_ack_i high.
REQ-014 wb_valid_o, rd_sel_o, rd_wena_o  out  1 each; rd_waddr_o  out  5; alu_result_o, dmem_data_o  out  32  registered MEM/WB outputs.
REQ-015 misalign_o, timeout_o  out  1 each  one-cycle error pulses, aligned with wb_valid_o.

Function
REQ-016 FSM SHALL have states IDLE and BUS; bus_req_o = (state==BUS).
REQ-017 IDLE, valid_i & !dmem_ena_i: next cycle wb_valid_o=1 with inputs passed through; stall_o=0; 1-cycle latency.
REQ-018 IDLE, valid_i & dmem_ena_i & aligned: stall_o=1, capture address/be/wdata/controls, go to BUS.
REQ-019 Misaligned = word with addr[1:0]!=0, or half with addr[0]=1; SHALL not issue a bus request; next cycle wb_valid_o=1, misalign_o=1, rd_wena_o=0; stall_o=0.
REQ-020 bus_be_o: word 1111; half 0011 (addr[1]=0) or 1100; byte 0001 shifted left by addr[1:0].
REQ-021 bus_wdata_o: word rt; half {2{rt[15:0]}}; byte {4{rt[7:0]}}; bus_we_o = captured dmem_wena_i.
REQ-022 bus_addr_o, bus_be_o, bus_wdata_o, bus_we_o SHALL remain stable throughout BUS.
REQ-023 BUS: stall_o = !bus_ack_i; on bus_ack_i go IDLE; next cycle wb_valid_o=1 with dmem_data_o = selected lane of bus_rdata_i extended per captured type/signed (stores: dmem_data_o=0).
REQ-024 Latency: request in cycle T+1 after start cycle T; ack in T+1+k gives wb_valid_o in T+2+k.
REQ-025 Wait counter SHALL clear on BUS entry and increment each BUS cycle without ack; at MAX_WAIT cycles without ack: drop bus_req_o, return IDLE, next cycle wb_valid_o=1, timeout_o=1, rd_wena_o=0; stall_o=0 in that cycle.
REQ-026 bus_ack_i in the same cycle as timeout SHALL win (normal completion, no timeout_o).
REQ-027 bus_ack_i while IDLE SHALL be ignored.
REQ-028 wb_valid_o SHALL be 0 in every cycle with no completion; when wb_valid_o=0, rd_wena_o SHALL be 0.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, counter 0, every output 0 (including bus_req_o and stall_o), even mid-transaction.
REQ-030 After release, first valid_i SHALL be handled as in IDLE; an abandoned transaction SHALL produce no wb_valid_o.

Verification
REQ-031 ALU op, alu_result_i=0x1234, rd_waddr_i=5, rd_wena_i=1 -> next cycle wb_valid_o=1, alu_result_o=0x1234, rd_waddr_o=5, stall_o never high.
REQ-032 Signed byte load addr 0x00000003, ack after 2 wait cycles, bus_rdata_i=0x80FF_FF7F -> bus_be_o=1000, stall_o high 3 cycles, dmem_data_o=0xFFFF_FF80.
REQ-033 Half store addr 0x6, rt=0x0000_ABCD -> bus_be_o=1100, bus_wdata_o=0xABCD_ABCD, bus_addr_o=1, bus_we_o=1.
REQ-034 Word load addr 0x2 -> no bus_req_o, misalign_o=1, wb_valid_o=1, rd_wena_o=0 next cycle.
REQ-035 MAX_WAIT=4, no ack -> bus_req_o high exactly 4 cycles, then timeout_o=1, rd_wena_o=0; repeat with ack in 4th cycle -> normal completion.
REQ-036 rst_n_i low during BUS -> bus_req_o and stall_o 0 immediately, no wb_valid_o after release.
